// File: rtl/midi_tx_bridge_if.sv
// ---------------------------------------------------------------------------
// midi_tx_bridge_if
//   Groups the byte-capture, UART-launch and status signals of the MIDI
//   transmit bridge into one bundle.
//
//   Parameters
//     DEPTH  FIFO depth in bytes; sizes fifo_count
//     CNT_W  width of the sent-byte counter
//
//   Signals (direction seen from the bridge, i.e. the slave modport)
//     byte_in      in   MIDI byte from the detector
//     byte_valid   in   detector ready level, one byte per rising edge
//     tx_data      out  byte presented to the UART
//     new_tx_data  out  one-cycle launch strobe
//     tx_busy      in   UART is transmitting
//     tx_block     in   AVR receive buffer full, holds off launches
//     fifo_count   out  current FIFO occupancy, 0..DEPTH
//     overflow     out  sticky byte-dropped flag
//     ovf_clr      in   synchronous clear of overflow
//     byte_count   out  number of bytes launched, wrapping
//
//   Modports
//     master  the surrounding system (detector, UART, debug logic)
//     slave   the bridge itself
// ---------------------------------------------------------------------------
interface midi_tx_bridge_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic [7:0]             tx_data;
  logic                   new_tx_data;
  logic                   tx_busy;
  logic                   tx_block;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   ovf_clr;
  logic [CNT_W-1:0]       byte_count;

  modport master (
    output byte_in, byte_valid, tx_busy, tx_block, ovf_clr,
    input  tx_data, new_tx_data, fifo_count, overflow, byte_count
  );

  modport slave (
    input  byte_in, byte_valid, tx_busy, tx_block, ovf_clr,
    output tx_data, new_tx_data, fifo_count, overflow, byte_count
  );
endinterface

// File: rtl/midi_tx_bridge.sv
// ---------------------------------------------------------------------------
// midi_tx_bridge
//   Buffered forwarding stage between the MIDI byte detector and the AVR
//   serial transmitter. Each rising edge of byte_valid captures one byte;
//   System Real-Time bytes (0xF8..0xFF) are optionally discarded; the rest
//   are queued in a circular FIFO and launched one at a time to the UART
//   whenever it is neither busy nor blocked.
//
//   Parameters
//     DEPTH      FIFO depth in bytes, power of two, 2..256
//     FILTER_RT  1 = discard 0xF8..0xFF before the FIFO, 0 = forward all
//     CNT_W      width of the sent-byte counter
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   midi_tx_bridge_if.slave (byte capture, UART launch, status)
// ---------------------------------------------------------------------------
module midi_tx_bridge #(
  parameter int DEPTH     = 16,
  parameter bit FILTER_RT = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  midi_tx_bridge_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] BCNT_ONE = CNT_W'(1);

  // LAUNCH holds the strobe for one cycle; GUARD gives the UART a cycle to
  // raise tx_busy before the next launch decision is taken.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    GUARD  = 2'd2
  } state_e;

  state_e           state_q;
  logic             valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       tx_data_q;
  logic             new_tx_data_q;
  logic             overflow_q;
  logic [CNT_W-1:0] byte_count_q;

  logic accept;
  logic rt_byte;
  logic full;
  logic push;
  logic drop;
  logic pop;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    count_d = count_q;

    accept  = bus.byte_valid & ~valid_q;
    rt_byte = FILTER_RT & (bus.byte_in >= 8'hF8);
    // Fullness is judged on the registered (pre-pop) occupancy, so a byte
    // arriving on the same edge as a pop from a full FIFO is still dropped.
    full    = (count_q == OCC_FULL);
    push    = accept & ~rt_byte & ~full;
    drop    = accept & ~rt_byte & full;
    pop     = (state_q == IDLE) & (count_q != '0) & ~bus.tx_busy & ~bus.tx_block;

    if (push && !pop) begin
      count_d = count_q + OCC_ONE;
    end else if (pop && !push) begin
      count_d = count_q - OCC_ONE;
    end
  end

  // NOTE: the byte storage has no reset; emptiness is tracked by the pointers
  // and the count alone, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= bus.byte_in;
    end
  end

  // Input edge detect, FIFO bookkeeping, status and the output FSM.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_q       <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      overflow_q    <= 1'b0;
      byte_count_q  <= '0;
    end else begin
      valid_q <= bus.byte_valid;
      count_q <= count_d;

      if (push) begin
        tail_q <= tail_q + PTR_ONE;
      end

      // A drop in the same cycle as a clear request wins.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q     <= mem_q[head_q];
            new_tx_data_q <= 1'b1;
            head_q        <= head_q + PTR_ONE;
            byte_count_q  <= byte_count_q + BCNT_ONE;
            state_q       <= LAUNCH;
          end
        end
        LAUNCH: begin
          new_tx_data_q <= 1'b0;
          state_q       <= GUARD;
        end
        GUARD: begin
          state_q <= IDLE;
        end
        default: begin
          new_tx_data_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_data_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.byte_count  = byte_count_q;

endmodule
